// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel registered multiplexer with manual selection and
// an auto-scan mode that dwells DWELL cycles on each channel.
//
// Optional build macro CHAN_SCAN_MASK_EN adds input ch_mask[N-1:0]. A 1 in
// ch_mask enables that channel. Scanning skips disabled channels, and a
// sel_load to a disabled channel is rejected like an out-of-range index.
// When the macro is undefined, all N channels are always enabled.
//
// Timing: state, cur_sel, out, out_valid and sel_err are all registered.
// out on edge t+1 is the channel that cur_sel named before edge t+1.
module chan_scan_mux #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in,
  input  logic [SW-1:0]   sel,
  input  logic            sel_load,
  input  logic            mode,
`ifdef CHAN_SCAN_MASK_EN
  input  logic [N-1:0]    ch_mask,
`endif
  output logic [W-1:0]    out,
  output logic [SW-1:0]   cur_sel,
  output logic            out_valid,
  output logic            sel_err
);

  // Width of the dwell counter. It must hold values 0..DWELL-1.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  // MANUAL follows the manual index. SCAN steps through enabled channels.
  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] dwell_cnt;

  // Per-channel enable vector. Without the mask feature, every channel is
  // enabled.
  logic [N-1:0] en;
`ifdef CHAN_SCAN_MASK_EN
  assign en = ch_mask;
`else
  assign en = {N{1'b1}};
`endif

  logic any_en;
  assign any_en = |en;

  // A sel_load is legal only when it names an existing and enabled channel.
  // An index >= N matches no channel, so it stays illegal.
  logic sel_legal;
  always_comb begin
    sel_legal = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) sel_legal = en[k];
    end
  end

  // Next enabled channel above cur_sel. If none is found, wrap to the lowest
  // enabled channel. With no channel enabled, stay on cur_sel.
  logic [SW-1:0] next_sel;
  logic          next_found;
  always_comb begin
    next_sel   = cur_sel;
    next_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!next_found && (SW'(k) > cur_sel) && en[k]) begin
        next_sel   = SW'(k);
        next_found = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!next_found && en[k]) begin
        next_sel   = SW'(k);
        next_found = 1'b1;
      end
    end
  end

  // Data mux and enable bit of the channel cur_sel currently points at.
  logic [W-1:0] chan_data;
  logic         cur_en;
  always_comb begin
    chan_data = '0;
    cur_en    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cur_sel == SW'(k)) begin
        chan_data = in[k*W +: W];
        cur_en    = en[k];
      end
    end
  end

  // Mode FSM, dwell counter, channel pointer and registered outputs.
  // - A legal load always wins over a same-cycle scan advance.
  // - In MANUAL the dwell counter is held at 0, so entering SCAN starts a
  //   fresh dwell on the current channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      dwell_cnt <= '0;
      cur_sel   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= mode ? SCAN : MANUAL;
      out       <= chan_data;
      out_valid <= any_en && ((state == SCAN) || cur_en);
      sel_err   <= sel_load && !sel_legal;
      if (sel_load && sel_legal) begin
        cur_sel   <= sel;
        dwell_cnt <= '0;
      end else if (state == SCAN) begin
        if (dwell_cnt == CW'(DWELL - 1)) begin
          dwell_cnt <= '0;
          cur_sel   <= next_sel;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Testbench for chan_scan_mux.
// The bench has two DUT instances: N=8 (main) and N=6 (range checks and wrap
// on a non-power-of-two N). A behavioural model tracks the N=8 instance every
// cycle. Table vectors and short hand-written sequences cover the corner
// cases.
module tb_chan_scan_mux;

  localparam int N     = 8;
  localparam int W     = 1;
  localparam int DWELL = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0] in8   = '0;
  logic [2:0] sel8  = '0;
  logic       load8 = 1'b0;
  logic       mode8 = 1'b0;
  logic [7:0] mask8 = 8'hFF;
  logic       out8;
  logic [2:0] cur8;
  logic       valid8;
  logic       err8;

  logic [5:0] in6   = '0;
  logic [2:0] sel6  = '0;
  logic       load6 = 1'b0;
  logic       mode6 = 1'b0;
  logic [5:0] mask6 = 6'h3F;
  logic       out6;
  logic [2:0] cur6;
  logic       valid6;
  logic       err6;

  chan_scan_mux #(.N(8), .W(1), .DWELL(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .sel_load(load8),
    .mode(mode8),
`ifdef CHAN_SCAN_MASK_EN
    .ch_mask(mask8),
`endif
    .out(out8), .cur_sel(cur8), .out_valid(valid8), .sel_err(err8)
  );

  chan_scan_mux #(.N(6), .W(1), .DWELL(4)) u6 (
    .clk(clk), .rst_n(rst_n), .in(in6), .sel(sel6), .sel_load(load6),
    .mode(mode6),
`ifdef CHAN_SCAN_MASK_EN
    .ch_mask(mask6),
`endif
    .out(out6), .cur_sel(cur6), .out_valid(valid6), .sel_err(err6)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (N=8 instance) ----------------
  // The model tracks the mode after its one-cycle lag, the selected channel,
  // the cycles spent on the channel, and the expected registered outputs.
  bit   m_scan;
  int   m_cur;
  int   m_age;
  logic m_out;
  logic m_valid;
  logic m_err;

  function automatic bit m_legal(input int s, input logic [7:0] mk);
    return (s < N) && mk[s];
  endfunction

  function automatic int m_next(input int c, input logic [7:0] mk);
    for (int i = 1; i <= N; i++) begin
      if (mk[(c + i) % N]) return (c + i) % N;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_scan  = 1'b0;
    m_cur   = 0;
    m_age   = 0;
    m_out   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Driver/monitor step. It samples the inputs, advances one clock edge,
  // updates the model, then compares all outputs 1 time unit after the edge.
  task automatic tick();
    logic [7:0] in_c;
    logic [2:0] sel_c;
    logic       ld_c;
    logic       md_c;
    logic [7:0] mk_c;
    in_c  = in8;
    sel_c = sel8;
    ld_c  = load8;
    md_c  = mode8;
    mk_c  = mask8;
    @(posedge clk);
    m_out   = in_c[m_cur];
    m_valid = (mk_c != 8'h00) && (m_scan || mk_c[m_cur]);
    m_err   = ld_c && !m_legal(int'(sel_c), mk_c);
    if (ld_c && m_legal(int'(sel_c), mk_c)) begin
      m_cur = int'(sel_c);
      m_age = 0;
    end else if (m_scan) begin
      m_age++;
      if (m_age == DWELL) begin
        m_age = 0;
        m_cur = m_next(m_cur, mk_c);
      end
    end else begin
      m_age = 0;
    end
    m_scan = md_c;
    #1;
    chk("model_out", out8, m_out);
    chk("model_cur_sel", cur8, m_cur);
    chk("model_out_valid", valid8, m_valid);
    chk("model_sel_err", err8, m_err);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [2:0] sel;
    logic       exp_out;
  } man_vec_t;

  typedef struct {
    logic [2:0] cur;
    logic       exp_out;
  } scan_vec_t;

  man_vec_t  mv[8];
  scan_vec_t sv[8];

  // Watchdog: every wait is edge-counted, so this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Manual loads into in=10101010 give channel bits 0,1,0,1,...
    mv[0] = '{3'd0, 1'b0}; mv[1] = '{3'd1, 1'b1};
    mv[2] = '{3'd2, 1'b0}; mv[3] = '{3'd3, 1'b1};
    mv[4] = '{3'd4, 1'b0}; mv[5] = '{3'd5, 1'b1};
    mv[6] = '{3'd6, 1'b0}; mv[7] = '{3'd7, 1'b1};
    // Scan over in=11001100 gives channel bits 0,0,1,1,0,0,1,1.
    sv[0] = '{3'd0, 1'b0}; sv[1] = '{3'd1, 1'b0};
    sv[2] = '{3'd2, 1'b1}; sv[3] = '{3'd3, 1'b1};
    sv[4] = '{3'd4, 1'b0}; sv[5] = '{3'd5, 1'b0};
    sv[6] = '{3'd6, 1'b1}; sv[7] = '{3'd7, 1'b1};

    // Reset state.
    model_reset();
    in8 = 8'hFF;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out", out8, 0);
    chk("rst_cur_sel", cur8, 0);
    chk("rst_out_valid", valid8, 0);
    chk("rst_sel_err", err8, 0);
    chk("rst6_cur_sel", cur6, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in8 = 8'h00;
    tick();
    chk("valid_after_release", valid8, 1);

    // Manual selection, one load every 10 cycles.
    in8 = 8'b10101010;
    for (int i = 0; i < 8; i++) begin
      sel8 = mv[i].sel;
      load8 = 1'b1;
      tick();
      load8 = 1'b0;
      chk("man_cur_sel", cur8, mv[i].sel);
      tick();
      chk("man_out", out8, mv[i].exp_out);
      repeat (8) tick();
    end

    // Auto-scan from channel 0. Each channel is held for DWELL cycles, then
    // the scan wraps from 7 to 0.
    sel8 = 3'd0;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    tick();
    in8 = 8'b11001100;
    mode8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < DWELL; j++) begin
        tick();
        chk("scan_cur_sel", cur8, sv[i].cur);
        if (j > 0) chk("scan_out", out8, sv[i].exp_out);
      end
    end
    tick();
    chk("scan_wrap_cur_sel", cur8, 0);
    chk("scan_wrap_out", out8, sv[7].exp_out);

    // Load during SCAN at dwell count 2. The load wins, and a fresh dwell
    // starts on channel 6.
    sel8 = 3'd3;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    chk("scan_load3", cur8, 3);
    tick();
    tick();
    sel8 = 3'd6;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    chk("scan_load6", cur8, 6);
    for (int j = 1; j < DWELL; j++) begin
      tick();
      chk("scan_hold6", cur8, 6);
    end
    tick();
    chk("scan_adv7", cur8, 7);

    // Out-of-range index on the N=6 instance.
    in6 = 6'b100100;
    sel6 = 3'd2;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    chk("n6_cur_sel_2", cur6, 2);
    chk("n6_no_err", err6, 0);
    sel6 = 3'd7;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    chk("n6_err_sel7", err6, 1);
    chk("n6_hold_sel7", cur6, 2);
    tick();
    chk("n6_err_one_cycle", err6, 0);
    chk("n6_hold_after", cur6, 2);
    sel6 = 3'd6;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    chk("n6_err_sel6", err6, 1);
    chk("n6_hold_sel6", cur6, 2);
    sel6 = 3'd5;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    chk("n6_err_sel5", err6, 0);
    chk("n6_cur_sel_5", cur6, 5);
    tick();
    chk("n6_out_ch5", out6, 1);
    // Scan wrap on N=6 goes from channel 5 back to 0.
    mode6 = 1'b1;
    for (int j = 0; j < DWELL; j++) begin
      tick();
      chk("n6_scan_hold5", cur6, 5);
    end
    tick();
    chk("n6_scan_wrap0", cur6, 0);
    mode6 = 1'b0;

    // Assert reset between clock edges during a scan.
    in8 = 8'hFF;
    tick();
    tick();
    chk("pre_rst_out", out8, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_out", out8, 0);
    chk("midrst_cur_sel", cur8, 0);
    chk("midrst_out_valid", valid8, 0);
    chk("midrst_sel_err", err8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < DWELL; j++) begin
      tick();
      chk("post_rst_cur0", cur8, 0);
    end
    tick();
    chk("post_rst_cur1", cur8, 1);

    // Randomized traffic checked against the model.
    for (int c = 0; c < 600; c++) begin
      in8 = 8'($urandom);
      sel8 = 3'($urandom_range(0, 7));
      load8 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) mode8 = ~mode8;
`ifdef CHAN_SCAN_MASK_EN
      if ($urandom_range(0, 15) == 0) mask8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`endif
      tick();
    end
    load8 = 1'b0;
    mask8 = 8'hFF;
    tick();

`ifdef CHAN_SCAN_MASK_EN
    // Masked scan visits enabled channels 1,4,7 and then wraps to 1.
    mode8 = 1'b0;
    mask8 = 8'b10010010;
    tick();
    tick();
    sel8 = 3'd1;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    chk("mask_load1", cur8, 1);
    sel8 = 3'd2;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    chk("mask_disabled_err", err8, 1);
    chk("mask_disabled_hold", cur8, 1);
    mode8 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < DWELL; j++) begin
        tick();
        chk("mask_scan_seq", cur8, (s == 0) ? 1 : (s == 1) ? 4 : 7);
      end
    end
    tick();
    chk("mask_scan_wrap", cur8, 1);
    mask8 = 8'h00;
    tick();
    chk("mask_zero_valid", valid8, 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("mask_zero_hold", cur8, 1);
      chk("mask_zero_valid_hold", valid8, 0);
    end
    mask8 = 8'hFF;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_scan_mux.md
CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 The block SHALL have parameter N, default 8, number of input channels (2..64).
REQ-002 The block SHALL have parameter W, default 1, bit width per channel.
REQ-003 The block SHALL have parameter DWELL, default 4, clock cycles per channel in scan mode (1..256).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in  input  N*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 The block SHALL have port sel  input  SW=max(1,clog2(N))  manual channel index.
REQ-008 The block SHALL have port sel_load  input  1  one-cycle strobe that captures sel.
REQ-009 The block SHALL have port mode  input  1  0 = manual, 1 = auto-scan.
REQ-010 The block SHALL have port out  output  W  registered selected channel data.
REQ-011 The block SHALL have port cur_sel  output  SW  channel index currently driving out.
REQ-012 The block SHALL have port out_valid  output  1  high when out reflects a legal channel.
REQ-013 The block SHALL have port sel_err  output  1  one-cycle pulse on an out-of-range sel_load.

Function
REQ-014 The block SHALL implement two states: MANUAL (mode=0) and SCAN (mode=1); the state SHALL follow mode, registered, one cycle after mode changes.
REQ-015 out SHALL equal in channel cur_sel as sampled on the previous edge (latency 1 cycle from in or cur_sel to out).
REQ-016 In MANUAL, sel_load=1 with sel<N SHALL set cur_sel to sel on the next edge; otherwise cur_sel SHALL hold.
REQ-017 sel_load=1 with sel>=N SHALL leave cur_sel unchanged and pulse sel_err for exactly one cycle.
REQ-018 In SCAN, a dwell counter SHALL count 0..DWELL-1; at DWELL-1, cur_sel SHALL advance by one and the counter SHALL return to 0.
REQ-019 cur_sel SHALL wrap from N-1 to 0 during scanning.
REQ-020 A legal sel_load in SCAN SHALL load cur_sel from sel and restart the dwell counter at 0; sel_load SHALL take priority over a same-cycle advance.
REQ-021 Entering SCAN from MANUAL SHALL start scanning from the current cur_sel with the dwell counter at 0.
REQ-022 With DWELL=1, cur_sel SHALL advance on every cycle while in SCAN.
REQ-023 out_valid SHALL be 1 one cycle after reset release and SHALL stay 1, except as stated in REQ-029.

Reset
REQ-024 While rst_n=0, the block SHALL force out=0, cur_sel=0, out_valid=0, sel_err=0, dwell counter=0, and state=MANUAL, independent of clk.
REQ-025 Reset asserted mid-dwell or mid-scan SHALL discard all progress; after release, operation SHALL resume from channel 0 in the state given by mode.

Configuration
REQ-026 Macro CHAN_SCAN_MASK_EN SHALL, when defined, add input ch_mask [N-1:0], where 1 means the channel is enabled.
REQ-027 With CHAN_SCAN_MASK_EN, SCAN SHALL advance to the next enabled channel in ascending order with wrap, skipping disabled channels, in one step.
REQ-028 With CHAN_SCAN_MASK_EN, a sel_load to a disabled channel SHALL be treated as out-of-range (REQ-017).
REQ-029 With CHAN_SCAN_MASK_EN and ch_mask all zeros, cur_sel SHALL hold and out_valid SHALL be 0; if cur_sel's own channel is disabled in MANUAL, out_valid SHALL be 0.
REQ-030 Without CHAN_SCAN_MASK_EN, no ch_mask port SHALL exist, and all N channels SHALL be enabled.

Verification
REQ-031 The bench SHALL cover: N=8, W=1, in=8'b10101010, MANUAL, sel_load sel=0..7 one per 10 cycles -> out = 0,1,0,1,0,1,0,1 one cycle after each load.
REQ-032 The bench SHALL cover: in=8'b11001100, mode=1, DWELL=4 -> cur_sel steps 0..7 every 4 cycles, wraps 7->0, and out follows 0,0,1,1,0,0,1,1.
REQ-033 The bench SHALL cover: N=6, sel_load sel=7 -> sel_err pulses for 1 cycle, and cur_sel is unchanged.
REQ-034 The bench SHALL cover: SCAN at cur_sel=3 with dwell count 2, then sel_load sel=6 -> cur_sel=6 next cycle, and the next advance to 7 occurs 4 cycles later.
REQ-035 The bench SHALL cover: rst_n pulled low mid-scan between clock edges -> outputs reach zero immediately, and scanning restarts from channel 0 after release.
REQ-036 The bench SHALL cover, with CHAN_SCAN_MASK_EN: ch_mask=8'b10010010 in SCAN -> cur_sel sequence 1,4,7,1; then ch_mask=0 -> out_valid=0 and cur_sel holds.
